// File: rtl/datapath_pkg.sv
// Shared types and encodings for the register-file/ALU datapath controller.
package datapath_pkg;

    localparam int unsigned OPC_W_DEF  = 3;
    localparam int unsigned PERF_W_DEF = 16;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_DECODE  = 3'd1,
        S_WR_IMM  = 3'd2,
        S_GET_A   = 3'd3,
        S_GET_B   = 3'd4,
        S_COMPUTE = 3'd5,
        S_WR_REG  = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    // Instruction class flags derived from the latched opcode/op.
    typedef struct packed {
        logic movi;
        logic movr;
        logic mvn;
        logic alu;
        logic cmp;
        logic legal;
    } ins_t;

    // Control word presented to the datapath.
    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] alu_op;
        logic       write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller sequencing the 16-bit register-file/ALU datapath.
// Optional retired-instruction counter enabled by DATAPATH_CTRL_PERF_EN.
module datapath_ctrl
    import datapath_pkg::*;
#(
    parameter int unsigned OPC_W = OPC_W_DEF
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W = PERF_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       op,
    output logic             w,
    output logic [2:0]       nsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       alu_op,
    output logic             write,
    output logic             illegal
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] retired
`endif
);

    state_t           state, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [1:0]       op_q, op_d;
    logic             accept;
    ins_t             ins;
    ctrl_t            ctrl_q, ctrl_d;

    function automatic ins_t classify(input logic [OPC_W-1:0] opc, input logic [1:0] o);
        ins_t c;
        c.movi  = (opc == OPC_W'(OPC_MOV)) && (o == MOV_IMM);
        c.movr  = (opc == OPC_W'(OPC_MOV)) && (o == MOV_REG);
        c.alu   = (opc == OPC_W'(OPC_ALU));
        c.mvn   = c.alu && (o == ALU_MVN);
        c.cmp   = c.alu && (o == ALU_SUB);
        c.legal = c.movi | c.movr | c.alu;
        return c;
    endfunction

    // Instruction fields are captured only when a start is accepted in WAIT.
    assign accept = (state == S_WAIT) && s;
    assign opc_d  = accept ? opcode : opc_q;
    assign op_d   = accept ? op : op_q;
    assign ins    = classify(opc_d, op_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            opc_q <= '0;
            op_q  <= '0;
        end else begin
            state <= state_d;
            opc_q <= opc_d;
            op_q  <= op_d;
        end
    end

    // Next state, and the control word that state_d will present once registered.
    always_comb begin
        state_d = S_WAIT;
        ctrl_d  = '0;

        case (state)
            S_WAIT:    state_d = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (ins.movi)                 state_d = S_WR_IMM;
                else if (ins.movr || ins.mvn) state_d = S_GET_B;
                else if (ins.alu)             state_d = S_GET_A;
                else                          state_d = S_WAIT;
            end
            S_WR_IMM:  state_d = S_WAIT;
            S_GET_A:   state_d = S_GET_B;
            S_GET_B:   state_d = S_COMPUTE;
            S_COMPUTE: state_d = ins.cmp ? S_WAIT : S_WR_REG;
            S_WR_REG:  state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase

        case (state_d)
            S_WAIT:   ctrl_d.w = 1'b1;
            S_DECODE: ctrl_d.illegal = ~ins.legal;
            S_WR_IMM: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.vsel  = VSEL_IMM8;
                ctrl_d.write = 1'b1;
            end
            S_GET_A: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.nsel  = NSEL_RM;
                ctrl_d.loadb = 1'b1;
                ctrl_d.bsel  = 1'b0;
            end
            S_COMPUTE: begin
                // MOV reg passes B through the adder as 0 + B.
                ctrl_d.alu_op = ins.movr ? ALU_ADD : op_d;
                ctrl_d.asel   = ins.movr;
                ctrl_d.loads  = ins.alu;
                ctrl_d.loadc  = ~ins.cmp;
            end
            S_WR_REG: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.vsel  = VSEL_C;
                ctrl_d.write = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            ctrl_q.w <= 1'b1;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign w       = ctrl_q.w;
    assign nsel    = ctrl_q.nsel;
    assign loada   = ctrl_q.loada;
    assign loadb   = ctrl_q.loadb;
    assign loadc   = ctrl_q.loadc;
    assign loads   = ctrl_q.loads;
    assign asel    = ctrl_q.asel;
    assign bsel    = ctrl_q.bsel;
    assign vsel    = ctrl_q.vsel;
    assign alu_op  = ctrl_q.alu_op;
    assign write   = ctrl_q.write;
    assign illegal = ctrl_q.illegal;

`ifdef DATAPATH_CTRL_PERF_EN
    // Count instructions that complete; illegal ones exit from DECODE and are skipped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if ((state == S_WR_IMM) || (state == S_WR_REG) ||
                     ((state == S_COMPUTE) && ins.cmp)) begin
            retired <= retired + PERF_W'(1);
        end
    end
`endif

endmodule
